// File: rtl/truth_table_sequencer_pkg.sv
// rtl/truth_table_sequencer_pkg.sv - shared states and reference truth tables for the sequencer
package tt_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Two-input tables, bit i = R for stim==i with A=stim[1], B=stim[0]
    localparam logic [3:0] IMPLICATION_TT = 4'b1011;
    localparam logic [3:0] AND_TT         = 4'b1000;
    localparam logic [3:0] OR_TT          = 4'b1110;
    localparam logic [3:0] XOR_TT         = 4'b0110;

    typedef enum logic [1:0] {
        GATE_IMPL = 2'd0,
        GATE_AND  = 2'd1,
        GATE_OR   = 2'd2,
        GATE_XOR  = 2'd3
    } gate_e;

    function automatic logic [3:0] gate_tt(input gate_e g);
        logic [3:0] w_tt;
        w_tt = IMPLICATION_TT;
        case (g)
            GATE_IMPL: w_tt = IMPLICATION_TT;
            GATE_AND:  w_tt = AND_TT;
            GATE_OR:   w_tt = OR_TT;
            GATE_XOR:  w_tt = XOR_TT;
            default:   w_tt = IMPLICATION_TT;
        endcase
        return w_tt;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// rtl/truth_table_sequencer_if.sv - stimulus/result bundle between sequencer and its controller
interface truth_table_sequencer_if #(
    parameter int N_IN = 2
);
    logic              start;
    logic              r_in;
    logic [N_IN-1:0]   stim;
    logic              busy;
    logic              sample_valid;
    logic [N_IN-1:0]   sample_idx;
    logic              done;
    logic              pass;
    logic [N_IN:0]     mismatch_cnt;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_idx;

    modport slave (
        input  start, r_in,
        output stim, busy, sample_valid, sample_idx, done, pass,
               mismatch_cnt, first_fail_valid, first_fail_idx
    );

    modport master (
        output start, r_in,
        input  stim, busy, sample_valid, sample_idx, done, pass,
               mismatch_cnt, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/truth_table_sequencer_hold_counter.sv
// rtl/truth_table_sequencer_hold_counter.sv - HOLD-cycle divider with last-cycle strobe
module tt_hold_counter #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last
);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic [CW-1:0] r_cnt;

    // With HOLD=1 LAST is 0, so every enabled cycle is a strobe
    assign o_last = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all gate input combinations and checks results against a truth table
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int                  N_IN   = 2,
    parameter int                  HOLD   = 4,
    parameter logic [2**N_IN-1:0]  EXPECT = IMPLICATION_TT
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_sequencer_if.slave bus
);
    localparam int              NCOMB    = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NCOMB - 1);
    localparam logic [N_IN:0]   CNT_MAX  = (N_IN+1)'(NCOMB);

    state_t          r_state;
    state_t          w_next_state;
    logic [N_IN-1:0] r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_mismatch_cnt;
    logic            r_ff_valid;
    logic [N_IN-1:0] r_ff_idx;

    logic            w_start_acc;
    logic            w_in_drive;
    logic            w_sample;
    logic            w_mismatch;
    logic            w_final;
    logic [N_IN:0]   w_cnt_next;

    assign w_in_drive  = (r_state == S_DRIVE);
    assign w_start_acc = bus.start && !w_in_drive;

    tt_hold_counter #(
        .HOLD (HOLD)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_acc),
        .i_en    (w_in_drive),
        .o_last  (w_sample)
    );

    assign w_mismatch = w_sample && (bus.r_in != EXPECT[r_stim]);
    assign w_final    = w_sample && (r_stim == LAST_IDX);
    assign w_cnt_next = (w_mismatch && (r_mismatch_cnt != CNT_MAX))
                        ? r_mismatch_cnt + 1'b1 : r_mismatch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_DRIVE;
            S_DRIVE: if (w_final)   w_next_state = S_DONE;
            S_DONE:  if (bus.start) w_next_state = S_DRIVE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Results are cleared on an accepted start; start during DRIVE never reaches here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_mismatch_cnt <= '0;
            r_ff_valid     <= 1'b0;
            r_ff_idx       <= '0;
        end else if (w_start_acc) begin
            r_stim         <= '0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_mismatch_cnt <= '0;
            r_ff_valid     <= 1'b0;
            r_ff_idx       <= '0;
        end else if (w_sample) begin
            r_mismatch_cnt <= w_cnt_next;
            if (w_mismatch && !r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_idx   <= r_stim;
            end
            if (w_final) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_cnt_next == '0);
            end else begin
                r_stim <= r_stim + 1'b1;
            end
        end
    end

    assign bus.stim             = r_stim;
    assign bus.busy             = r_busy;
    assign bus.sample_valid     = w_sample;
    assign bus.sample_idx       = w_sample ? r_stim : '0;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.mismatch_cnt     = r_mismatch_cnt;
    assign bus.first_fail_valid = r_ff_valid;
    assign bus.first_fail_idx   = r_ff_idx;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed-vector bench for truth_table_sequencer
module tb_truth_table_sequencer;
    import tt_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode4 = 0;
    int   mode1 = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(2)) u_if4 ();
    truth_table_sequencer_if #(.N_IN(2)) u_if1 ();

    // mode 0: A->B model, 1: tied high, 2: tied low
    assign u_if4.r_in = (mode4 == 0) ? (~u_if4.stim[1] | u_if4.stim[0]) : (mode4 == 1);
    assign u_if1.r_in = (mode1 == 0) ? (~u_if1.stim[1] | u_if1.stim[0]) : (mode1 == 1);

    truth_table_sequencer #(.N_IN(2), .HOLD(4), .EXPECT(IMPLICATION_TT)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4.slave)
    );

    truth_table_sequencer #(.N_IN(2), .HOLD(1), .EXPECT(IMPLICATION_TT)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start4();
        u_if4.start = 1'b1;
        cycle();
        u_if4.start = 1'b0;
    endtask

    task automatic wait_done4();
        for (int i = 0; i < 200 && !u_if4.done; i++) cycle();
        check("done4_reached", u_if4.done, 1);
    endtask

    task automatic check_results4(input string tag, input int cnt, input int ffv,
                                  input int ffi, input int pss);
        check({tag, "_mismatch_cnt"}, u_if4.mismatch_cnt, cnt);
        check({tag, "_ff_valid"},     u_if4.first_fail_valid, ffv);
        check({tag, "_ff_idx"},       u_if4.first_fail_idx, ffi);
        check({tag, "_pass"},         u_if4.pass, pss);
        check({tag, "_busy"},         u_if4.busy, 0);
        check({tag, "_stim_final"},   u_if4.stim, 3);
    endtask

    // Cycle-exact sweep on the HOLD=4 unit; pulse_k >= 0 injects a start during DRIVE
    task automatic sweep4_timed(input string tag, input int pulse_k);
        start4();
        check({tag, "_busy_start"}, u_if4.busy, 1);
        for (int k = 0; k < 16; k++) begin
            if (k == pulse_k) u_if4.start = 1'b1;
            if (k == pulse_k + 1) u_if4.start = 1'b0;
            check($sformatf("%s_stim_k%0d", tag, k), u_if4.stim, k / 4);
            check($sformatf("%s_sv_k%0d", tag, k), u_if4.sample_valid, (k % 4) == 3);
            if ((k % 4) == 3)
                check($sformatf("%s_sidx_k%0d", tag, k), u_if4.sample_idx, k / 4);
            check($sformatf("%s_done_k%0d", tag, k), u_if4.done, 0);
            cycle();
        end
        u_if4.start = 1'b0;
        check({tag, "_done_at_16"}, u_if4.done, 1);
    endtask

    initial begin
        u_if4.start = 1'b0;
        u_if1.start = 1'b0;
        cycle();
        cycle();
        check("rst_stim",     u_if4.stim, 0);
        check("rst_busy",     u_if4.busy, 0);
        check("rst_done",     u_if4.done, 0);
        check("rst_pass",     u_if4.pass, 0);
        check("rst_sv",       u_if4.sample_valid, 0);
        check("rst_sidx",     u_if4.sample_idx, 0);
        check("rst_cnt",      u_if4.mismatch_cnt, 0);
        check("rst_ffv",      u_if4.first_fail_valid, 0);
        check("rst_ffi",      u_if4.first_fail_idx, 0);
        rst = 1'b0;
        cycle();

        // correct A->B gate
        mode4 = 0;
        sweep4_timed("t1", -1);
        check_results4("t1", 0, 0, 0, 1);

        // tied high: only idx 2 (A=1,B=0) expects 0
        mode4 = 1;
        start4();
        wait_done4();
        check_results4("t2", 1, 1, 2, 0);

        // tied low: idx 0,1,3 expect 1
        mode4 = 2;
        start4();
        wait_done4();
        check_results4("t3", 3, 1, 0, 0);

        // restart from a failed DONE clears everything
        mode4 = 0;
        start4();
        check("t6_cnt_cleared",  u_if4.mismatch_cnt, 0);
        check("t6_ffv_cleared",  u_if4.first_fail_valid, 0);
        check("t6_done_cleared", u_if4.done, 0);
        check("t6_stim_zero",    u_if4.stim, 0);
        wait_done4();
        check_results4("t6", 0, 0, 0, 1);

        // HOLD=1 unit samples every cycle
        mode1 = 0;
        u_if1.start = 1'b1;
        cycle();
        u_if1.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_sv_k%0d", k),   u_if1.sample_valid, 1);
            check($sformatf("t4_sidx_k%0d", k), u_if1.sample_idx, k);
            check($sformatf("t4_stim_k%0d", k), u_if1.stim, k);
            check($sformatf("t4_done_k%0d", k), u_if1.done, 0);
            cycle();
        end
        check("t4_done",      u_if1.done, 1);
        check("t4_pass",      u_if1.pass, 1);
        check("t4_sv_after",  u_if1.sample_valid, 0);
        check("t4_stim_hold", u_if1.stim, 3);

        // start during DRIVE at idx 1 is ignored
        mode4 = 0;
        sweep4_timed("t5", 5);
        check_results4("t5", 0, 0, 0, 1);

        // reset in the middle of idx 2
        start4();
        for (int k = 0; k < 9; k++) cycle();
        check("t5_mid_stim", u_if4.stim, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5r_busy", u_if4.busy, 0);
        check("t5r_stim", u_if4.stim, 0);
        check("t5r_cnt",  u_if4.mismatch_cnt, 0);
        check("t5r_done", u_if4.done, 0);
        check("t5r_sv",   u_if4.sample_valid, 0);
        cycle();
        check("t5r_idle_stim", u_if4.stim, 0);
        check("t5r_idle_busy", u_if4.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
